sha256_round_engine: RTL and testbench

SHA-256 compression engine for a single 512-bit block. It sits downstream of the W-schedule generator and consumes W[0..63] through that block's read/ready interface, one word per cycle. It runs the 64 rounds against an on-chip K[0..63] constant table and adds the result into the incoming chaining value. It shares `local_go_sig` with the W generator and returns the 256-bit intermediate hash with a `done` flag.

---
 rtl/sha256_round_engine.sv | 144 ++++++++++++++
 tb/tb_sha256_round_engine.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_engine.sv
// SHA-256 compression of one 512-bit block: streams W[0..63] from the schedule generator,
// runs 64 rounds against the K table and folds the working state into the chaining value.
module sha256_round_engine (
  input  logic         clock,
  input  logic         reset,
  input  logic         local_go_sig,
  input  logic [255:0] h_in,
  input  logic         w_reg_rdy,
  input  logic [31:0]  w_reg_data,
  output logic         w_reg_read,
  output logic [5:0]   w_reg_addr,
  output logic [255:0] hash_out,
  output logic         done
);
  localparam int width32 = 32;
  localparam int width6  = 6;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_RDY, RUN, DRAIN, FINAL, DONE} state_t;

  state_t              state, state_nxt;
  logic                reset_q, go_q, rdy_q;
  logic [width32-1:0]  data_q;
  logic [255:0]        h_in_q;
  logic [width6-1:0]   round_cnt;
  logic [1:0]          drain_cnt;
  logic [2:0]          valid_pipe;
  logic [width32-1:0]  hv   [8];
  logic [width32-1:0]  wk   [8];
  logic [width32-1:0]  hsum [8];
  logic [width32-1:0]  t1, t2;
  logic                round_en;

  function automatic logic [width32-1:0] rotr(input logic [width32-1:0] x, input int n);
    return (x >> n) | (x << (width32 - n));
  endfunction

  function automatic logic [width32-1:0] k_const(input logic [width6-1:0] idx);
    logic [width32-1:0] k;
    k = '0;
    case (idx)
      6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; 6'd63: k = 32'hc67178f2;
      default: k = '0;
    endcase
    return k;
  endfunction

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    reset_q <= reset;
    go_q    <= local_go_sig;
    rdy_q   <= w_reg_rdy;
    data_q  <= w_reg_data;
    h_in_q  <= h_in;
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (go_q) state_nxt = LOAD;
      LOAD:     state_nxt = WAIT_RDY;
      WAIT_RDY: if (rdy_q) state_nxt = RUN;
      RUN:      if (w_reg_addr == 6'd63) state_nxt = DRAIN;
      DRAIN:    if (drain_cnt == 2'd2) state_nxt = FINAL;
      FINAL:    state_nxt = DONE;
      DONE:     if (!go_q) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // The oldest valid tap lines up with the word currently held in data_q.
  always_comb begin
    round_en = valid_pipe[2] && (state == RUN || state == DRAIN);
    t1 = wk[7] + (rotr(wk[4], 6) ^ rotr(wk[4], 11) ^ rotr(wk[4], 25))
       + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6])) + k_const(round_cnt) + data_q;
    t2 = (rotr(wk[0], 2) ^ rotr(wk[0], 13) ^ rotr(wk[0], 22))
       + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
    for (int i = 0; i < 8; i++) hsum[i] = hv[i] + wk[i];
  end

  always_ff @(posedge clock) begin
    if (reset_q) begin
      state      <= IDLE;
      w_reg_read <= 1'b0;
      w_reg_addr <= '0;
      hash_out   <= '0;
      done       <= 1'b0;
      round_cnt  <= '0;
      drain_cnt  <= '0;
      valid_pipe <= '0;
    end else begin
      state      <= state_nxt;
      valid_pipe <= {valid_pipe[1:0], w_reg_read};
      done       <= (state_nxt == DONE);
      w_reg_read <= (state_nxt == RUN);
      w_reg_addr <= (state_nxt == RUN && state == RUN) ? w_reg_addr + 6'd1 : '0;
      if (state == LOAD) begin
        round_cnt <= '0;
        drain_cnt <= '0;
      end
      if (round_en) round_cnt <= round_cnt + 6'd1;
      if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
      if (state == FINAL)
        hash_out <= {hsum[0], hsum[1], hsum[2], hsum[3], hsum[4], hsum[5], hsum[6], hsum[7]};
    end
  end

  // NOTE: working and chaining registers carry no reset; LOAD always initialises them before use.
  always_ff @(posedge clock) begin
    if (state == LOAD) begin
      for (int i = 0; i < 8; i++) begin
        hv[i] <= h_in_q[255 - width32*i -: width32];
        wk[i] <= h_in_q[255 - width32*i -: width32];
      end
    end else if (state == FINAL) begin
      for (int i = 0; i < 8; i++) hv[i] <= hsum[i];
    end else if (round_en) begin
      wk[7] <= wk[6];
      wk[6] <= wk[5];
      wk[5] <= wk[4];
      wk[4] <= wk[3] + t1;
      wk[3] <= wk[2];
      wk[2] <= wk[1];
      wk[1] <= wk[0];
      wk[0] <= t1 + t2;
    end
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine with a behavioural two-cycle-latency W generator
// and a software compression model for vectors without a published digest.
module tb_sha256_round_engine;
  logic         clock = 1'b0;
  logic         reset;
  logic         local_go_sig;
  logic [255:0] h_in;
  logic         w_reg_rdy;
  logic [31:0]  w_reg_data;
  logic         w_reg_read;
  logic [5:0]   w_reg_addr;
  logic [255:0] hash_out;
  logic         done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] k_tab [64];
  logic [31:0] w_mem [64];
  logic        gen_v;
  logic [5:0]  gen_a;

  localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2  = {480'h0, 32'h000001c0};

  sha256_round_engine dut (
    .clock(clock), .reset(reset), .local_go_sig(local_go_sig), .h_in(h_in),
    .w_reg_rdy(w_reg_rdy), .w_reg_data(w_reg_data), .w_reg_read(w_reg_read),
    .w_reg_addr(w_reg_addr), .hash_out(hash_out), .done(done)
  );

  always #5 clock = ~clock;

  // Generator model: a read at cycle n puts W on the bus during cycle n+2, garbage otherwise.
  always @(posedge clock) begin
    if (reset) begin
      gen_v      <= 1'b0;
      gen_a      <= '0;
      w_reg_data <= '0;
    end else begin
      gen_v      <= w_reg_read;
      gen_a      <= w_reg_addr;
      w_reg_data <= gen_v ? w_mem[gen_a] : 32'hdeadbeef;
    end
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic load_schedule(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) w_mem[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w_mem[t] = (rotr(w_mem[t-2], 17) ^ rotr(w_mem[t-2], 19) ^ (w_mem[t-2] >> 10)) + w_mem[t-7]
               + (rotr(w_mem[t-15], 7) ^ rotr(w_mem[t-15], 18) ^ (w_mem[t-15] >> 3)) + w_mem[t-16];
  endtask

  // Reference compression over whatever schedule is currently in w_mem.
  function automatic logic [255:0] sw_compress(input logic [255:0] hin);
    logic [31:0]  v [8];
    logic [31:0]  x1, x2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tab[t] + w_mem[t];
      x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + x1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  // Runs one block from go to done; checks the read stream and the r0 / done timing.
  task automatic run_block(input string tag, input logic [255:0] h0, input logic [511:0] blk,
                           input int rdy_delay, input bit drop_rdy);
    int nreads, r0, last_rd, done_cyc, rdy_at, exp_r0;
    load_schedule(blk);
    local_go_sig = 1'b0;
    w_reg_rdy    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    h_in = h0;
    local_go_sig = 1'b1;
    rdy_at = 3 + rdy_delay;
    if (rdy_delay == 0) w_reg_rdy = 1'b1;
    exp_r0 = (rdy_delay == 0) ? 4 : rdy_at + 2;
    nreads = 0; r0 = -1; last_rd = -1; done_cyc = -1;
    for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
      @(posedge clock); #1;
      if (rdy_delay > 0 && cyc == rdy_at) w_reg_rdy = 1'b1;
      if (drop_rdy && r0 >= 0 && cyc == r0 + 5) w_reg_rdy = 1'b0;
      if (w_reg_read === 1'b1) begin
        if (nreads == 0) r0 = cyc;
        checks++;
        if (w_reg_addr !== 6'(nreads) || nreads >= 64 || (nreads > 0 && last_rd != cyc - 1)) begin
          failures++;
          $display("FAIL %s read_seq: cycle=%0d addr=%0d read_no=%0d prev_read_cycle=%0d",
                   tag, cyc, w_reg_addr, nreads, last_rd);
        end
        last_rd = cyc;
        nreads++;
      end
      if (done === 1'b1) done_cyc = cyc;
    end
    checks++;
    if (done_cyc < 0) begin failures++; $display("FAIL %s done_timeout: done never rose within 300 cycles", tag); end
    checks++;
    if (nreads != 64) begin failures++; $display("FAIL %s read_count: got %0d expected 64", tag, nreads); end
    checks++;
    if (r0 != exp_r0) begin failures++; $display("FAIL %s r0_cycle: got %0d expected %0d", tag, r0, exp_r0); end
    checks++;
    if (done_cyc != r0 + 68) begin
      failures++; $display("FAIL %s done_latency: got %0d expected %0d", tag, done_cyc - r0, 68);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; local_go_sig = 1'b0; w_reg_rdy = 1'b0; h_in = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++; if (w_reg_read !== 1'b0) begin failures++; $display("FAIL reset_read: got %b expected 0", w_reg_read); end
    checks++; if (w_reg_addr !== 6'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", w_reg_addr); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (hash_out !== 256'h0) begin failures++; $display("FAIL reset_hash: got %h expected 0", hash_out); end
  endtask

  task automatic test_abc();
    run_block("abc", IV, ABC_BLK, 0, 1'b0);
    checks++;
    if (hash_out !== ABC_DIG) begin failures++; $display("FAIL abc_digest: got %h expected %h", hash_out, ABC_DIG); end
  endtask

  task automatic test_go_hold();
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b1 || w_reg_read !== 1'b0 || hash_out !== ABC_DIG) begin
        failures++;
        $display("FAIL go_hold: cycle=%0d done=%b read=%b hash=%h expected done=1 read=0 hash=%h",
                 i, done, w_reg_read, hash_out, ABC_DIG);
      end
    end
    local_go_sig = 1'b0;
    @(posedge clock); #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL go_drop_early: done=%b expected 1", done); end
    @(posedge clock); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL go_drop_idle: done=%b expected 0", done); end
    checks++;
    if (hash_out !== ABC_DIG) begin failures++; $display("FAIL go_drop_hash: got %h expected %h", hash_out, ABC_DIG); end
  endtask

  task automatic test_two_block();
    logic [255:0] mid_exp, mid_dut;
    run_block("blk1", IV, TWO_B1, 10, 1'b1);
    mid_exp = sw_compress(IV);
    mid_dut = hash_out;
    checks++;
    if (mid_dut !== mid_exp) begin failures++; $display("FAIL blk1_digest: got %h expected %h", mid_dut, mid_exp); end
    run_block("blk2", mid_dut, TWO_B2, 0, 1'b0);
    checks++;
    if (hash_out !== TWO_DIG) begin failures++; $display("FAIL two_block_digest: got %h expected %h", hash_out, TWO_DIG); end
  endtask

  task automatic test_reset_mid_run();
    int r0;
    load_schedule(ABC_BLK);
    local_go_sig = 1'b0; w_reg_rdy = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    h_in = IV; local_go_sig = 1'b1;
    r0 = -1;
    for (int cyc = 1; cyc <= 20 && r0 < 0; cyc++) begin
      @(posedge clock); #1;
      if (w_reg_read === 1'b1) r0 = cyc;
    end
    checks++;
    if (r0 < 0) begin failures++; $display("FAIL rst_run_start: no read within 20 cycles"); end
    repeat (30) @(posedge clock);
    #1;
    reset = 1'b1; local_go_sig = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (w_reg_read !== 1'b0 || w_reg_addr !== 6'd0 || done !== 1'b0 || hash_out !== 256'h0) begin
      failures++;
      $display("FAIL rst_outputs: read=%b addr=%0d done=%b hash=%h expected all zero", w_reg_read, w_reg_addr, done, hash_out);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      checks++;
      if (w_reg_read !== 1'b0 || done !== 1'b0) begin
        failures++; $display("FAIL rst_quiet: cycle=%0d read=%b done=%b expected 0 0", i, w_reg_read, done);
      end
    end
    run_block("abc_after_rst", IV, ABC_BLK, 0, 1'b0);
    checks++;
    if (hash_out !== ABC_DIG) begin failures++; $display("FAIL rst_abc_digest: got %h expected %h", hash_out, ABC_DIG); end
  endtask

  task automatic test_zero_block();
    logic [255:0] exp;
    run_block("zero", 256'h0, 512'h0, 3, 1'b0);
    exp = sw_compress(256'h0);
    checks++;
    if (hash_out !== exp) begin failures++; $display("FAIL zero_digest: got %h expected %h", hash_out, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    k_tab = '{32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
              32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
              32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
              32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
              32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
              32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
              32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
              32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    for (int t = 0; t < 64; t++) w_mem[t] = '0;
    test_reset();
    test_abc();
    test_go_hold();
    test_two_block();
    test_reset_mid_run();
    test_zero_block();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
